// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//   Packs RV32I instruction fields into a 32-bit instruction word and buffers
//   the result in a 2-entry FIFO with valid/ready handshakes on both sides.
//   A request whose format select is not one-hot is replaced by a NOP
//   (addi x0,x0,0) and raises a sticky error flag.
//
//   Optional feature (macro INST_ENCODER_RANGE_CHECK_EN):
//     when defined, the immediate is range-checked against its format on
//     acceptance; an out-of-range immediate also yields a NOP and sets o_err.
//     When undefined, immediates are truncated silently.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_valid / o_ready   request handshake
//   i_fmt               one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J
//   i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm   request fields
//   o_valid / i_ready   encoded-word handshake
//   o_inst              FIFO head (encoded instruction word)
//   o_level             FIFO occupancy 0..2
//   o_err               sticky encode error, cleared only by reset
// ---------------------------------------------------------------------------
module inst_encoder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [5:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [1:0]  o_level,
    output logic        o_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } level_e;

    // -----------------------------------------------------------------------
    // Encoder (combinational)
    // -----------------------------------------------------------------------
    logic        fmt_onehot;
    logic        is_shift;
    logic        range_ok;
    logic [31:0] packed_word;
    logic [31:0] enc_word;
    logic        enc_err;

    always_comb begin
        fmt_onehot = (i_fmt != 6'd0) && ((i_fmt & (i_fmt - 6'd1)) == 6'd0);
        // Immediate shifts reuse the I format but carry funct7 in imm[11:5].
        is_shift   = (i_opcode == 7'b0010011) &&
                     ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));

        packed_word = NOP;
        if (i_fmt[0]) begin
            packed_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        end else if (i_fmt[1]) begin
            if (is_shift) begin
                packed_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
            end else begin
                packed_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
        end else if (i_fmt[2]) begin
            packed_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        end else if (i_fmt[3]) begin
            packed_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
        end else if (i_fmt[4]) begin
            packed_word = {i_imm[31:12], i_rd, i_opcode};
        end else if (i_fmt[5]) begin
            packed_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                           i_rd, i_opcode};
        end

`ifdef INST_ENCODER_RANGE_CHECK_EN
        // A value fits in N signed bits when bits [31:N-1] are all equal.
        range_ok = 1'b1;
        if (i_fmt[1] || i_fmt[2]) begin
            if (i_fmt[1] && is_shift) begin
                range_ok = ~|i_imm[31:5];
            end else begin
                range_ok = (&i_imm[31:11]) | (~|i_imm[31:11]);
            end
        end else if (i_fmt[3]) begin
            range_ok = ((&i_imm[31:12]) | (~|i_imm[31:12])) & ~i_imm[0];
        end else if (i_fmt[5]) begin
            range_ok = ((&i_imm[31:20]) | (~|i_imm[31:20])) & ~i_imm[0];
        end else if (i_fmt[4]) begin
            range_ok = ~|i_imm[11:0];
        end
`else
        range_ok = 1'b1;
`endif

        enc_err  = !(fmt_onehot && range_ok);
        enc_word = enc_err ? NOP : packed_word;
    end

    // -----------------------------------------------------------------------
    // 2-entry FIFO, level tracked as a three-state FSM
    // -----------------------------------------------------------------------
    level_e      state_q, state_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic        err_q, err_d;
    logic        push, pop;

    // Ready comes from registered state only, so i_ready never reaches o_ready.
    assign o_ready = (state_q != FULL);
    assign o_valid = (state_q != EMPTY);
    assign o_level = state_q;
    assign o_err   = err_q;
    assign o_inst  = o_valid ? mem_q[rd_ptr_q] : 32'd0;

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        err_d    = err_q;

        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            if (enc_err) begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case (state_q)
            EMPTY:   if (push)         state_d = ONE;
            ONE:     if (push && !pop) state_d = FULL;
                     else if (!push && pop) state_d = EMPTY;
            FULL:    if (pop)          state_d = ONE;
            default:                   state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= 32'd0;
            mem_q[1] <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [5:0]  i_fmt = 6'd0;
    logic [6:0]  i_opcode = 7'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [6:0]  i_funct7 = 7'd0;
    logic [4:0]  i_rd = 5'd0;
    logic [4:0]  i_rs1 = 5'd0;
    logic [4:0]  i_rs2 = 5'd0;
    logic [31:0] i_imm = 32'd0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_inst;
    logic [1:0]  o_level;
    logic        o_err;

    inst_encoder dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_fmt(i_fmt), .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_level(o_level),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;
    bit rnd_rdy  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: arithmetic bit placement. Returns {error, word}.
    function automatic logic [32:0] ref_enc(input logic [5:0] f, input logic [6:0] op,
            input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int unsigned w, u;
        int          s;
        bit          ok, shift;
        u = imm;
        s = $signed(imm);
        shift = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        ok = 1'b1;
        w  = 0;
        case (f)
            6'b000001: w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
            6'b000010: begin
                if (shift) w = f7 * 2**25 + (u % 32) * 2**20;
                else       w = (u % 4096) * 2**20;
                w = w + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
                ok = shift ? (u < 32) : (s >= -2048 && s <= 2047);
            end
            6'b000100: begin
                w = ((u / 32) % 128) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12
                    + (u % 32) * 2**7 + op;
                ok = (s >= -2048 && s <= 2047);
            end
            6'b001000: begin
                w = ((u / 4096) % 2) * 2**31 + ((u / 32) % 64) * 2**25 + rs2 * 2**20
                    + rs1 * 2**15 + f3 * 2**12 + ((u / 2) % 16) * 2**8
                    + ((u / 2048) % 2) * 2**7 + op;
                ok = (s >= -4096 && s <= 4095) && (u % 2 == 0);
            end
            6'b010000: begin
                w = (u / 4096) * 4096 + rd * 2**7 + op;
                ok = (u % 4096 == 0);
            end
            6'b100000: begin
                w = ((u / 2**20) % 2) * 2**31 + ((u / 2) % 1024) * 2**21
                    + ((u / 2048) % 2) * 2**20 + ((u / 4096) % 256) * 2**12
                    + rd * 2**7 + op;
                ok = (s >= -(2**20) && s <= 2**20 - 1) && (u % 2 == 0);
            end
            default: return {1'b1, 32'h13};
        endcase
`ifndef INST_ENCODER_RANGE_CHECK_EN
        ok = 1'b1;
`endif
        if (!ok) return {1'b1, 32'h13};
        return {1'b0, w};
    endfunction

    // Behavioural model: a queue of at most two expected words plus sticky error.
    logic [31:0] exp_q[$];
    bit          exp_err = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        logic [32:0] r;
        bit          do_push, do_pop;
        if (!i_rst_n) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            do_push = i_valid && (exp_q.size() < 2);
            do_pop  = (exp_q.size() != 0) && i_ready;
            r = ref_enc(i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(r[31:0]);
                if (r[32]) exp_err = 1'b1;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge i_clk) begin
        chk("level", {30'd0, o_level}, exp_q.size());
        chk("valid", {31'd0, o_valid}, {31'd0, exp_q.size() != 0});
        chk("ready", {31'd0, o_ready}, {31'd0, exp_q.size() < 2});
        chk("err",   {31'd0, o_err},   {31'd0, exp_err});
        if (exp_q.size() != 0) chk("inst", o_inst, exp_q[0]);
    end

    task automatic send(input logic [5:0] f, input logic [6:0] op, input logic [2:0] f3,
            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [31:0] imm);
        bit rdy;
        int n;
        i_valid = 1'b1; i_fmt = f; i_opcode = op; i_funct3 = f3; i_funct7 = f7;
        i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
        n = 0;
        forever begin
            if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
            rdy = o_ready;
            @(posedge i_clk);
            if (rdy) break;
            n++;
            if (n > 100) begin
                n_checks++; n_err++;
                $display("FAIL accept_timeout: got no acceptance in %0d cycles, required one", n);
                break;
            end
        end
        @(negedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    // Directed single request from an empty FIFO; word must show one cycle later.
    task automatic send_chk(input string nm, input logic [5:0] f, input logic [6:0] op,
            input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
            input logic [31:0] exp);
        i_ready = 1'b0;
        send(f, op, f3, f7, rd, rs1, rs2, imm);
        chk({nm, "_inst"}, o_inst, exp);
        chk({nm, "_valid"}, {31'd0, o_valid}, 32'd1);
        i_ready = 1'b1;
        idle(2);
    endtask

    initial begin
        logic [5:0]  f;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
        #1;
        chk("rst_level", {30'd0, o_level}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_err",   {31'd0, o_err},   32'd0);
        chk("rst_inst",  o_inst,           32'd0);
        idle(2);
        i_rst_n = 1'b1;

        send_chk("addi", 6'b000010, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
        send_chk("add",  6'b000001, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
        send_chk("beq",  6'b001000, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 32'hFE000EE3);
        send_chk("jal",  6'b100000, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF);
        send_chk("lui",  6'b010000, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7);
        chk("err_clean", {31'd0, o_err}, 32'd0);

        // Backpressure: three back-to-back requests with downstream stalled.
        i_ready = 1'b0;
        i_valid = 1'b1; i_fmt = 6'b000010; i_opcode = 7'h13; i_funct3 = 0; i_funct7 = 0;
        i_rd = 1; i_rs1 = 0; i_rs2 = 0; i_imm = 5;
        @(negedge i_clk); #1;
        i_fmt = 6'b000001; i_opcode = 7'h33; i_rd = 3; i_rs1 = 1; i_rs2 = 2; i_imm = 0;
        @(negedge i_clk); #1;
        chk("bp_level2", {30'd0, o_level}, 32'd2);
        chk("bp_ready0", {31'd0, o_ready}, 32'd0);
        chk("bp_head",   o_inst, 32'h00500093);
        i_fmt = 6'b100000; i_opcode = 7'h6F; i_rd = 1; i_rs1 = 0; i_rs2 = 0; i_imm = 8;
        @(negedge i_clk); #1;
        chk("bp_held_level", {30'd0, o_level}, 32'd2);
        chk("bp_held_head",  o_inst, 32'h00500093);
        i_ready = 1'b1;
        @(negedge i_clk); #1;
        chk("bp_out1", o_inst, 32'h002081B3);
        @(negedge i_clk); #1;
        chk("bp_out2", o_inst, 32'h008000EF);
        i_valid = 1'b0;
        @(negedge i_clk); #1;
        chk("bp_drained", {31'd0, o_valid}, 32'd0);

        // Reset mid-stream with two words buffered.
        i_ready = 1'b0;
        send(6'b000010, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7);
        send(6'b000010, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd9);
        chk("mid_level2", {30'd0, o_level}, 32'd2);
        #1 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_level", {30'd0, o_level}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_rst_err",   {31'd0, o_err},   32'd0);
        idle(1);
        i_rst_n = 1'b1;
        i_ready = 1'b1;

        // Random traffic with random downstream stalls.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0:       f = 6'($urandom);
                default: f = 6'd1 << $urandom_range(0, 5);
            endcase
            op = 7'($urandom);
            f3 = 3'($urandom);
            if (f == 6'b000010 && $urandom_range(0, 2) == 0) begin
                op = 7'h13;
                f3 = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
            end
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = $urandom_range(0, 31);
                2:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = {$urandom_range(0, 1) != 0 ? 12'hFFF : 12'h000, 20'($urandom)};
            endcase
            send(f, op, f3, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
        end
        rnd_rdy = 1'b0;
        i_ready = 1'b1;
        idle(4);

        // Error paths.
        send_chk("badfmt", 6'b000011, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00000013);
        chk("badfmt_err", {31'd0, o_err}, 32'd1);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        send_chk("addi2048", 6'b000010, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h00000013);
`else
        send_chk("addi2048", 6'b000010, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093);
`endif
        chk("err_sticky", {31'd0, o_err}, 32'd1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
